// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector with the following per-channel stages:
// - an optional synchroniser
// - a glitch filter
// - programmable edge qualification (rise/fall/both/off)
// - a registered tick, a direction flag, and a sticky event flag
module multi_edge_detector #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILTER_CYCLES = 1,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   i_wave,
    input  logic [2*CHANNELS-1:0] i_mode,
    input  logic [CHANNELS-1:0]   i_clr,
    output logic [CHANNELS-1:0]   o_level,
    output logic [CHANNELS-1:0]   o_tick,
    output logic [CHANNELS-1:0]   o_dir,
    output logic [CHANNELS-1:0]   o_event,
    output logic                  o_any_tick
);

    localparam int unsigned CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    logic [CHANNELS-1:0] w_s;
    logic [CHANNELS-1:0] w_tick_next;
    logic                r_any_tick;

    genvar g;
    for (g = 0; g < CHANNELS; g++) begin : gen_ch

        if (SYNC_STAGES > 0) begin : gen_sync
            logic [SYNC_STAGES-1:0] r_sync;

            // Synchroniser shift register; the last stage feeds the filter
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_sync <= {SYNC_STAGES{INIT_LEVEL}};
                end else begin
                    r_sync[0] <= i_wave[g];
                    for (int k = 1; k < int'(SYNC_STAGES); k++) begin
                        r_sync[k] <= r_sync[k-1];
                    end
                end
            end

            assign w_s[g] = r_sync[SYNC_STAGES-1];
        end else begin : gen_nosync
            assign w_s[g] = i_wave[g];
        end

        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_next;
        logic             r_level;
        logic             r_dir;
        logic             r_tick;
        logic             r_event;
        logic             w_level_next;
        logic             w_dir_next;
        logic             w_tick_ch;

        // Filter and qualification: accept a level once it persists FILTER_CYCLES samples
        always_comb begin
            w_cnt_next   = '0;
            w_level_next = r_level;
            w_dir_next   = r_dir;
            w_tick_ch    = 1'b0;
            if (w_s[g] != r_level) begin
                if (r_cnt == CNT_LAST) begin
                    w_level_next = w_s[g];
                    w_dir_next   = w_s[g];
                    w_tick_ch    = w_s[g] ? i_mode[2*g] : i_mode[2*g+1];
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
        end

        // Per-channel state; a new tick takes priority over a simultaneous clear
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt   <= '0;
                r_level <= INIT_LEVEL;
                r_dir   <= 1'b0;
                r_tick  <= 1'b0;
                r_event <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_next;
                r_level <= w_level_next;
                r_dir   <= w_dir_next;
                r_tick  <= w_tick_ch;
                r_event <= (r_event & ~i_clr[g]) | w_tick_ch;
            end
        end

        assign w_tick_next[g] = w_tick_ch;
        assign o_level[g]     = r_level;
        assign o_dir[g]       = r_dir;
        assign o_tick[g]      = r_tick;
        assign o_event[g]     = r_event;
    end

    // Aggregate tick, registered alongside the per-channel ticks
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_any_tick <= 1'b0;
        end else begin
            r_any_tick <= |w_tick_next;
        end
    end

    assign o_any_tick = r_any_tick;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Bench for multi_edge_detector.
// Three parameter sets share the same stimulus. Each is compared against a
// sample-window reference model.
module tb_multi_edge_detector;

    localparam int CH = 4;
    localparam int NC = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [CH-1:0]   wave;
    logic [CH-1:0]   clr;
    logic [2*CH-1:0] mode;

    logic [CH-1:0] lvl [NC];
    logic [CH-1:0] tck [NC];
    logic [CH-1:0] dr  [NC];
    logic [CH-1:0] ev  [NC];
    logic          any [NC];

    always #5 clk = ~clk;

    multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(2), .FILTER_CYCLES(1), .INIT_LEVEL(1'b0)) u_dut_def (
        .clk(clk), .rst_n(rst_n), .i_wave(wave), .i_mode(mode), .i_clr(clr),
        .o_level(lvl[0]), .o_tick(tck[0]), .o_dir(dr[0]), .o_event(ev[0]), .o_any_tick(any[0]));

    multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(2), .FILTER_CYCLES(4), .INIT_LEVEL(1'b0)) u_dut_f4 (
        .clk(clk), .rst_n(rst_n), .i_wave(wave), .i_mode(mode), .i_clr(clr),
        .o_level(lvl[1]), .o_tick(tck[1]), .o_dir(dr[1]), .o_event(ev[1]), .o_any_tick(any[1]));

    multi_edge_detector #(.CHANNELS(CH), .SYNC_STAGES(0), .FILTER_CYCLES(3), .INIT_LEVEL(1'b0)) u_dut_s0 (
        .clk(clk), .rst_n(rst_n), .i_wave(wave), .i_mode(mode), .i_clr(clr),
        .o_level(lvl[2]), .o_tick(tck[2]), .o_dir(dr[2]), .o_event(ev[2]), .o_any_tick(any[2]));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: an edge is accepted when the last F synchronised samples
    // all differ from the accepted level.
    int          sp [NC] = '{2, 2, 0};
    int          fp [NC] = '{1, 4, 3};
    logic [3:0]  past  [NC][CH];
    logic [7:0]  hist  [NC][CH];
    int          nsamp [NC][CH];
    logic [CH-1:0] m_level [NC];
    logic [CH-1:0] m_dir   [NC];
    logic [CH-1:0] m_tick  [NC];
    logic [CH-1:0] m_ev    [NC];

    task automatic step();
        logic s;
        logic acc;
        for (int c = 0; c < NC; c++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if (!rst_n) begin
                    past[c][ch]  = '0;
                    hist[c][ch]  = '0;
                    nsamp[c][ch] = 0;
                    m_level[c][ch] = 1'b0;
                    m_dir[c][ch]   = 1'b0;
                    m_tick[c][ch]  = 1'b0;
                    m_ev[c][ch]    = 1'b0;
                end else begin
                    s = (sp[c] == 0) ? wave[ch] : past[c][ch][sp[c]-1];
                    past[c][ch] = {past[c][ch][2:0], wave[ch]};
                    hist[c][ch] = {hist[c][ch][6:0], s};
                    if (nsamp[c][ch] < 8) nsamp[c][ch]++;
                    acc = (nsamp[c][ch] >= fp[c]);
                    for (int i = 0; i < fp[c]; i++)
                        if (hist[c][ch][i] == m_level[c][ch]) acc = 1'b0;
                    m_tick[c][ch] = 1'b0;
                    if (acc) begin
                        m_tick[c][ch]  = s ? mode[2*ch] : mode[2*ch+1];
                        m_level[c][ch] = s;
                        m_dir[c][ch]   = s;
                        nsamp[c][ch]   = 0;
                    end
                    m_ev[c][ch] = (m_ev[c][ch] & ~clr[ch]) | m_tick[c][ch];
                end
            end
        end
        @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            check_eq($sformatf("c%0d level", c), 32'(lvl[c]), 32'(m_level[c]));
            check_eq($sformatf("c%0d tick", c),  32'(tck[c]), 32'(m_tick[c]));
            check_eq($sformatf("c%0d dir", c),   32'(dr[c]),  32'(m_dir[c]));
            check_eq($sformatf("c%0d event", c), 32'(ev[c]),  32'(m_ev[c]));
            check_eq($sformatf("c%0d any", c),   32'(any[c]), 32'(|m_tick[c]));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        wave  = '0;
        clr   = '0;
        mode  = '1;
        repeat (3) step();
        check_eq("reset tick", 32'(tck[0]), 32'h0);
        check_eq("reset level", 32'(lvl[0]), 32'h0);
        rst_n = 1'b1;
        repeat (2) step();

        // Single rise on ch0: tick on edge 3 with default parameters
        wave[0] = 1'b1;
        step();
        check_eq("t1 e1 tick", 32'(tck[0][0]), 32'h0);
        step();
        check_eq("t1 e2 tick", 32'(tck[0][0]), 32'h0);
        step();
        check_eq("t1 e3 tick", 32'(tck[0][0]), 32'h1);
        check_eq("t1 e3 any", 32'(any[0]), 32'h1);
        check_eq("t1 e3 dir", 32'(dr[0][0]), 32'h1);
        check_eq("t1 e3 level", 32'(lvl[0][0]), 32'h1);
        step();
        check_eq("t1 e4 tick", 32'(tck[0][0]), 32'h0);
        repeat (8) step();

        // Sticky event, then clear colliding with a new tick
        check_eq("t4 event held", 32'(ev[0][0]), 32'h1);
        clr[0] = 1'b1;
        step();
        clr[0] = 1'b0;
        check_eq("t4 event cleared", 32'(ev[0][0]), 32'h0);
        wave[0] = 1'b0;
        step();
        step();
        clr[0] = 1'b1;
        step();
        check_eq("t4 set wins tick", 32'(tck[0][0]), 32'h1);
        check_eq("t4 set wins event", 32'(ev[0][0]), 32'h1);
        clr[0] = 1'b0;
        repeat (8) step();

        // Glitch filter on ch1: a 3-cycle pulse is rejected, a 4-cycle pulse is accepted
        wave[1] = 1'b1;
        repeat (3) step();
        wave[1] = 1'b0;
        repeat (10) step();
        check_eq("t2 short pulse level", 32'(lvl[1][1]), 32'h0);
        wave[1] = 1'b1;
        repeat (4) step();
        wave[1] = 1'b0;
        repeat (12) step();

        // Per-channel modes: ch2 rise only, ch3 fall only, period-20 square wave
        mode = {2'b10, 2'b01, 2'b11, 2'b11};
        for (int k = 0; k < 80; k++) begin
            if (k % 10 == 0) begin
                wave[2] = ~wave[2];
                wave[3] = ~wave[3];
            end
            step();
        end

        // All channels toggle together on the unsynchronised instance (F=3)
        mode = '1;
        wave = '0;
        repeat (10) step();
        wave = '1;
        step();
        step();
        check_eq("t6 e2 ticks", 32'(tck[2]), 32'h0);
        step();
        check_eq("t6 e3 ticks", 32'(tck[2]), 32'hF);
        check_eq("t6 e3 any", 32'(any[2]), 32'h1);
        repeat (8) step();

        // Reset while the inputs sit high, then one rise per channel after release
        rst_n = 1'b0;
        repeat (3) step();
        check_eq("t5 reset level", 32'(lvl[0]), 32'h0);
        rst_n = 1'b1;
        repeat (3) step();
        check_eq("t5 post-reset ticks", 32'(tck[0]), 32'hF);
        repeat (8) step();

        // Reset during filtering drops the pending edge
        wave = '0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("t5 dropped edge", 32'(tck[1] | tck[2]), 32'h0);
        end

        // Randomised traffic
        for (int k = 0; k < 2000; k++) begin
            for (int ch = 0; ch < CH; ch++) begin
                if ($urandom_range(5) == 0) wave[ch] = ~wave[ch];
                clr[ch] = ($urandom_range(7) == 0);
            end
            if ($urandom_range(49) == 0) mode = 8'($urandom);
            rst_n = ($urandom_range(299) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
